// File: rtl/ghost_mode_sched.sv
// ---------------------------------------------------------------------------
// ghost_mode_sched
//
// Per-ghost mode scheduler. It produces the 2-bit mode code for each ghost:
//   00 exit jail, 01 scatter, 10 attack, 11 return to jail.
// It releases ghosts from the house on a staggered tick timer, steps the
// global scatter/attack phase sequence, and runs the power-pellet
// frightened window. A frightened ghost that is eaten returns to jail and
// then leaves again.
//
// Optional feature macro: GHOST_FRIGHT_EN
//   defined   : frightened window, eaten handling and phase freeze present
//   undefined : no fright logic; ghost_fright is 0, power_pellet, level and
//               ghost_eaten are ignored, EATEN is never entered
//
// Ports
//   clk_50mhz     in   system clock
//   reset_n       in   asynchronous active-low reset
//   tick          in   one-cycle game tick strobe (60 Hz)
//   restart       in   one-cycle synchronous return to the reset state
//   level         in   current level (0/1), selects the fright window length
//   power_pellet  in   one-cycle pulse, pellet eaten
//   ghost_eaten   in   [3:0] per-ghost pulse, frightened ghost was caught
//   ghost_at_door in   [3:0] ghost is on the tile above the jail
//   ghost_at_home in   [3:0] ghost is on the jail tile
//   blinky_mode   out  [1:0] mode code, ghost 0
//   pinky_mode    out  [1:0] mode code, ghost 1
//   inky_mode     out  [1:0] mode code, ghost 2
//   clyde_mode    out  [1:0] mode code, ghost 3
//   ghost_active  out  [3:0] ghost has left the house
//   ghost_fright  out  [3:0] ghost is frightened
//   phase         out  [2:0] global phase index 0..5
// ---------------------------------------------------------------------------
module ghost_mode_sched #(
    parameter int SCATTER_TICKS       = 420,
    parameter int SCATTER_SHORT_TICKS = 300,
    parameter int CHASE_TICKS         = 1200,
    parameter int FRIGHT_TICKS        = 360,
    parameter int RELEASE_GAP         = 240
) (
    input  logic       clk_50mhz,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       restart,
    input  logic       level,
    input  logic       power_pellet,
    input  logic [3:0] ghost_eaten,
    input  logic [3:0] ghost_at_door,
    input  logic [3:0] ghost_at_home,
    output logic [1:0] blinky_mode,
    output logic [1:0] pinky_mode,
    output logic [1:0] inky_mode,
    output logic [1:0] clyde_mode,
    output logic [3:0] ghost_active,
    output logic [3:0] ghost_fright,
    output logic [2:0] phase
);

    typedef enum logic [1:0] {
        G_HOUSE = 2'd0,
        G_EXIT  = 2'd1,
        G_ROAM  = 2'd2,
        G_EATEN = 2'd3
    } ghost_state_e;

    localparam logic [10:0] SCATTER_LEN = 11'(SCATTER_TICKS);
    localparam logic [10:0] SHORT_LEN   = 11'(SCATTER_SHORT_TICKS);
    localparam logic [10:0] CHASE_LEN   = 11'(CHASE_TICKS);
    localparam logic [9:0]  REL_MAX     = 10'(3 * RELEASE_GAP);
    localparam logic [9:0]  REL_AT1     = 10'(RELEASE_GAP);
    localparam logic [9:0]  REL_AT2     = 10'(2 * RELEASE_GAP);
    localparam logic [2:0]  LAST_PHASE  = 3'd5;

    logic [2:0]       phase_q, phase_d;
    logic [10:0]      pcnt_q, pcnt_d;
    logic [9:0]       rel_q, rel_d;
    logic [3:0]       release_ok;
    logic [3:0]       fright_vec;
    logic [3:0]       eat_hit;
    logic             phase_freeze;
    logic             scatter_d;
    logic [3:0][1:0]  mode_vec;

    // Length loaded when entering phase p. P5 is terminal and never counts.
    function automatic logic [10:0] phase_len(input logic [2:0] p);
        case (p)
            3'd0, 3'd2: phase_len = SCATTER_LEN;
            3'd1, 3'd3: phase_len = CHASE_LEN;
            3'd4:       phase_len = SHORT_LEN;
            default:    phase_len = 11'd0;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Global scatter/attack phase sequencer
    // -----------------------------------------------------------------------
    // Freeze looks at the current fright bits, so a pellet arriving on the
    // same cycle as a phase expiry lets the phase advance first.
    assign phase_freeze = |fright_vec;

    always_comb begin
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        if (restart) begin
            phase_d = 3'd0;
            pcnt_d  = SCATTER_LEN;
        end else if (tick && !phase_freeze && (phase_q != LAST_PHASE)) begin
            if (pcnt_q == 11'd1) begin
                phase_d = phase_q + 3'd1;
                pcnt_d  = phase_len(phase_q + 3'd1);
            end else begin
                pcnt_d  = pcnt_q - 11'd1;
            end
        end
    end

    // Even phases are scatter; decoded from the next phase so the modes
    // change on the same edge as the phase output.
    assign scatter_d = (phase_d == 3'd0) || (phase_d == 3'd2) || (phase_d == 3'd4);

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 3'd0;
            pcnt_q  <= SCATTER_LEN;
        end else begin
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // House release timer
    // -----------------------------------------------------------------------
    always_comb begin
        rel_d = rel_q;
        if (restart) begin
            rel_d = 10'd0;
        end else if (tick && (rel_q < REL_MAX)) begin
            rel_d = rel_q + 10'd1;
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            rel_q <= 10'd0;
        end else begin
            rel_q <= rel_d;
        end
    end

    // Blinky's threshold is zero, so it is released unconditionally.
    assign release_ok = {rel_q >= REL_MAX, rel_q >= REL_AT2, rel_q >= REL_AT1, 1'b1};

    // -----------------------------------------------------------------------
    // Frightened window counter
    // -----------------------------------------------------------------------
`ifdef GHOST_FRIGHT_EN
    logic [8:0] fcnt_q, fcnt_d;
    logic [8:0] fright_load;
    logic       fright_expire;

    assign fright_load = level ? 9'(FRIGHT_TICKS >> 1) : 9'(FRIGHT_TICKS);

    // A pellet reload takes precedence over the tick decrement, including
    // the decrement that would otherwise end the window.
    always_comb begin
        fcnt_d        = fcnt_q;
        fright_expire = 1'b0;
        if (restart) begin
            fcnt_d = 9'd0;
        end else if (power_pellet) begin
            fcnt_d = fright_load;
        end else if (tick && (fcnt_q != 9'd0)) begin
            fcnt_d        = fcnt_q - 9'd1;
            fright_expire = (fcnt_q == 9'd1);
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q <= 9'd0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    // Being caught only counts while that ghost is frightened.
    assign eat_hit = ghost_eaten & fright_vec;
`else
    logic unused_fright_inputs;

    assign unused_fright_inputs = ^{level, power_pellet, ghost_eaten};
    assign eat_hit              = 4'b0000;
`endif

    // -----------------------------------------------------------------------
    // Per-ghost state machines
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_ghost
        ghost_state_e state_q, state_d;
        logic [1:0]   mode_q, mode_d;
        logic         active_q;
        logic         fright_d;

        always_comb begin
            state_d = state_q;
            case (state_q)
                G_HOUSE: if (release_ok[gi])    state_d = G_EXIT;
                G_EXIT:  if (ghost_at_door[gi]) state_d = G_ROAM;
                G_ROAM:  if (eat_hit[gi])       state_d = G_EATEN;
                G_EATEN: if (ghost_at_home[gi]) state_d = G_EXIT;
            endcase
            if (restart) begin
                state_d = G_HOUSE;
            end
        end

`ifdef GHOST_FRIGHT_EN
        logic fright_q;

        // Being eaten beats every other update; a pellet only frightens a
        // ghost that is out roaming.
        always_comb begin
            fright_d = fright_q;
            if (restart) begin
                fright_d = 1'b0;
            end else if (eat_hit[gi]) begin
                fright_d = 1'b0;
            end else if (power_pellet && (state_q == G_ROAM)) begin
                fright_d = 1'b1;
            end else if (fright_expire) begin
                fright_d = 1'b0;
            end
        end

        always_ff @(posedge clk_50mhz or negedge reset_n) begin
            if (!reset_n) begin
                fright_q <= 1'b0;
            end else begin
                fright_q <= fright_d;
            end
        end

        assign fright_vec[gi] = fright_q;
`else
        assign fright_d       = 1'b0;
        assign fright_vec[gi] = 1'b0;
`endif

        always_comb begin
            case (state_d)
                G_ROAM:  mode_d = (fright_d || scatter_d) ? 2'b01 : 2'b10;
                G_EATEN: mode_d = 2'b11;
                default: mode_d = 2'b00;
            endcase
        end

        always_ff @(posedge clk_50mhz or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= G_HOUSE;
                mode_q   <= 2'b00;
                active_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                mode_q   <= mode_d;
                active_q <= (state_d != G_HOUSE);
            end
        end

        assign mode_vec[gi]     = mode_q;
        assign ghost_active[gi] = active_q;
    end

    assign blinky_mode  = mode_vec[0];
    assign pinky_mode   = mode_vec[1];
    assign inky_mode    = mode_vec[2];
    assign clyde_mode   = mode_vec[3];
    assign ghost_fright = fright_vec;
    assign phase        = phase_q;

endmodule
